// File: rtl/nonce_search_ctrl_if.sv
// Bundle between the nonce search sequencer and its host/hash-core side.
// master = host + hash core side, slave = sequencer.
interface nonce_search_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic [255:0]     startNonce;
    logic [CNT_W-1:0] maxCount;
    logic [255:0]     target;
    logic [255:0]     hashNonce;
    logic [255:0]     hashDigest;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic [255:0]     foundNonce;
    logic [255:0]     foundHash;
    logic [CNT_W-1:0] hashCount;

    modport master (
        output start, abort, startNonce, maxCount, target, hashDigest,
        input  hashNonce, busy, found, exhausted, foundNonce, foundHash, hashCount
    );

    modport slave (
        input  start, abort, startNonce, maxCount, target, hashDigest,
        output hashNonce, busy, found, exhausted, foundNonce, foundHash, hashCount
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Walks nonces through an unpipelined hash core and reports the first digest below target.
// One nonce per LATENCY+1 cycles; start is ignored while busy, abort cancels at the next edge.
module nonce_search_ctrl #(
    parameter int LATENCY = 64,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    nonce_search_ctrl_if.slave bus
);
    localparam int             WCW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK} state_t;

    state_t           state_q, state_d;
    logic [255:0]     nonce_q, nonce_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] hash_count_q, hash_count_d;
    logic             found_q, found_d;
    logic             exhausted_q, exhausted_d;
    logic [255:0]     found_nonce_q, found_nonce_d;
    logic [255:0]     found_hash_q, found_hash_d;
    logic             hit;

    assign hit = bus.hashDigest < bus.target;

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        remaining_d   = remaining_q;
        wait_cnt_d    = wait_cnt_q;
        hash_count_d  = hash_count_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hash_count_d  = '0;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    found_hash_d  = '0;
                    if (bus.maxCount != '0) begin
                        nonce_d     = bus.startNonce;
                        remaining_d = bus.maxCount;
                        wait_cnt_d  = '0;
                        exhausted_d = 1'b0;
                        state_d     = S_WAIT;
                    end else begin
                        exhausted_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // An aborted check never counts as completed, even if it would have hit.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    hash_count_d = hash_count_q + CNT_W'(1);
                    if (hit) begin
                        found_d       = 1'b1;
                        found_nonce_d = nonce_q;
                        found_hash_d  = bus.hashDigest;
                        state_d       = S_IDLE;
                    end else if (remaining_q == CNT_W'(1)) begin
                        exhausted_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        nonce_d     = nonce_q + 256'd1;
                        remaining_d = remaining_q - CNT_W'(1);
                        wait_cnt_d  = '0;
                        state_d     = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            nonce_q       <= '0;
            remaining_q   <= '0;
            wait_cnt_q    <= '0;
            hash_count_q  <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            remaining_q   <= remaining_d;
            wait_cnt_q    <= wait_cnt_d;
            hash_count_q  <= hash_count_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

    assign bus.hashNonce  = nonce_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.found      = found_q;
    assign bus.exhausted  = exhausted_q;
    assign bus.foundNonce = found_nonce_q;
    assign bus.foundHash  = found_hash_q;
    assign bus.hashCount  = hash_count_q;
endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
Sequencer that sits directly upstream and downstream of the SHA-256 hash core. It drives the core's 256-bit nonce input and consumes the core's 256-bit digest. It walks consecutive nonces from a start value and compares each digest against a difficulty target. It reports the first nonce whose digest is strictly below the target, or reports exhaustion after a programmed number of attempts.

Parameters:
- LATENCY, 64, number of hash-core stages (clock edges from input change to valid digest)
- CNT_W, 32, width of attempt counter and maxCount

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a search; ignored while busy
- abort  in  1  cancel the running search
- startNonce  in  256  first nonce of the search
- maxCount  in  CNT_W  number of nonces to try
- target  in  256  difficulty threshold, bit 255 most significant
- hashNonce  out  256  registered nonce driven to the hash core input
- hashDigest  in  256  digest from the hash core output
- busy  out  1  search in progress
- found  out  1  sticky: hit found
- exhausted  out  1  sticky: maxCount tried, no hit
- foundNonce  out  256  nonce that hit
- foundHash  out  256  digest that hit
- hashCount  out  CNT_W  nonces fully checked in the current/last search

Behaviour:
- Reset:
  - Synchronous, active-low, one clock, one reset (rst_n).
  - All outputs and registers clear to 0; state goes to IDLE.
  - Reset mid-search abandons it immediately.
  - The hash core has no reset, so no digest is trusted until a full WAIT completes.
- Core input constraint: the core's message schedule is not pipelined, so hashNonce is held stable for LATENCY consecutive edges per nonce. Throughput is one nonce per LATENCY+1 cycles.
- States: IDLE, WAIT, CHECK.
- IDLE:
  - If start=1 and maxCount≠0, on that edge (E0):
    - hashNonce←startNonce, curNonce←startNonce, remaining←maxCount.
    - waitCnt←0, hashCount←0, found←0, exhausted←0, foundNonce←0, foundHash←0.
    - busy←1, go to WAIT.
  - If start=1 and maxCount=0: clear the same flags, set exhausted←1, stay in IDLE, busy stays 0, no nonce issued.
- WAIT:
  - waitCnt increments each edge.
  - On the edge where waitCnt==LATENCY-1 (the LATENCY-th edge after E0), go to CHECK.
- CHECK (one cycle):
  - hashDigest is valid for hashNonce. hit = hashDigest < target (unsigned 256-bit, strict; equality is a miss).
  - On the exit edge, hashCount increments by 1 in all cases.
  - If hit: found←1, foundNonce←curNonce, foundHash←hashDigest, busy←0, go to IDLE.
  - Else if remaining==1: exhausted←1, busy←0, go to IDLE.
  - Else: curNonce←curNonce+1 and hashNonce←curNonce+1 (mod 2^256; all-ones wraps to 0). Also remaining−1, waitCnt←0, go to WAIT. This edge acts as the new E0.
- abort:
  - In WAIT or CHECK: go to IDLE next edge with busy←0. found and exhausted stay 0; hashCount keeps completed checks only.
  - abort takes priority over a simultaneous CHECK hit.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: start wins.
- start while busy is ignored.
- found, exhausted, foundNonce and foundHash hold until the next accepted start or reset.
- hashNonce holds its last value in IDLE.
- Cycles from the start edge to the found/exhausted assertion edge for N nonces: N×(LATENCY+1).

Test Plan:
- Known vector:
  - Stimulus: startNonce=0, maxCount=1, target=66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2926.
  - Required: found=1 and busy=0 exactly 65 edges after the start edge; foundHash=66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925; foundNonce=0; hashCount=1.
- Strict compare:
  - Stimulus: same as the known vector but target=66687aad…0d5f2925 (equal to the digest).
  - Required: exhausted=1, found=0 at edge 65, hashCount=1.
- Exhaustion:
  - Stimulus: startNonce=5, maxCount=3, target=0.
  - Required: hashNonce sequence 5,6,7, each held 65 cycles; exhausted=1 at edge 195; hashCount=3; foundNonce=0.
- Wrap-around:
  - Stimulus: startNonce=all-ones, maxCount=2, target=0.
  - Required: hashNonce becomes 0 at edge 65; exhausted at edge 130.
- Abort and restart:
  - Stimulus: start with maxCount=10, assert abort at cycle 100 together with start=1.
  - Required: busy=0 next edge, found=exhausted=0, hashCount=1. A new start with all-ones target then hits after 65 edges.
- Zero count and reset:
  - Stimulus: start with maxCount=0.
  - Required: exhausted=1 next edge, busy never 1.
  - Stimulus: rst_n=0 during WAIT.
  - Required: all outputs 0 on the next edge.
